// File: rtl/fifo_rr_drain.sv
// fifo_rr_drain: round-robin drain of N show-ahead FIFOs into a one-entry valid/ready stage; FIFO_RR_DRAIN_CNT_EN adds a saturating xfer_count
module fifo_rr_drain #(
  parameter int N    = 4,
  parameter int bits = 8,
  parameter int SW   = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    fifo_empty,
  input  logic [N*bits-1:0] fifo_dout,
  output logic [N-1:0]    fifo_pop,
  output logic            out_valid,
  output logic [bits-1:0] out_data,
  output logic [SW-1:0]   out_src,
  input  logic            out_ready
`ifdef FIFO_RR_DRAIN_CNT_EN
  ,
  output logic [15:0]     xfer_count
`endif
);
  typedef enum logic {IDLE, FULL} state_e;
  state_e state_q, state_d;
  logic [bits-1:0] data_q, data_d;
  logic [SW-1:0] src_q, src_d, last_q, last_d, gnt, idx;
  logic any, load;
  // scan from the source after the last grant, wrapping, and take the first non-empty one
  always_comb begin
    gnt = last_q;
    any = 1'b0;
    idx = '0;
    for (int k = 1; k <= N; k++) begin
      idx = SW'((int'(last_q) + k) % N);
      if (!any && !fifo_empty[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
  end
  assign load     = !rst && en && (state_q == IDLE || out_ready) && any;
  assign fifo_pop = load ? ({{(N-1){1'b0}}, 1'b1} << gnt) : '0;
  // a grant overwrites the output stage even while the old word is being accepted
  always_comb begin
    state_d = load ? FULL : (state_q == FULL && out_ready) ? IDLE : state_q;
    data_d  = load ? fifo_dout[gnt*bits +: bits] : data_q;
    src_d   = load ? gnt : src_q;
    last_d  = load ? gnt : last_q;
  end
  // state register; last starts at N-1 so source 0 wins first after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      src_q   <= '0;
      last_q  <= SW'(N - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      last_q  <= last_d;
    end
  end
  assign out_valid = state_q == FULL;
  assign out_data  = data_q;
  assign out_src   = src_q;
`ifdef FIFO_RR_DRAIN_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  assign cnt_d = (out_valid && out_ready && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  // accepted-transfer counter, sticks at all ones
  always_ff @(posedge clk) begin
    cnt_q <= rst ? '0 : cnt_d;
  end
  assign xfer_count = cnt_q;
`endif
endmodule

// File: tb/tb_fifo_rr_drain.sv
// tb_fifo_rr_drain: randomized and directed bench for fifo_rr_drain against a queue-based reference model
module tb_fifo_rr_drain;
  localparam int N = 4;
  localparam int B = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic out_ready = 1'b0;
  logic [N-1:0] fifo_empty = '1;
  logic [N-1:0] fifo_pop;
  logic [N*B-1:0] fifo_dout = '0;
  logic out_valid;
  logic [B-1:0] out_data;
  logic [1:0] out_src;
`ifdef FIFO_RR_DRAIN_CNT_EN
  logic [15:0] xfer_count;
  int m_cnt = 0;
`endif
  int checks = 0;
  int errors = 0;
  logic [B-1:0] q[N][$];
  logic [B-1:0] acc[$];
  logic armed = 1'b0;
  logic m_valid = 1'b0;
  logic [B-1:0] m_data = '0;
  int m_src = 0;
  int m_last = N - 1;
  logic m_load = 1'b0;
  int m_gnt = 0;
  logic [B-1:0] m_word = '0;

  always #5 clk = ~clk;

  fifo_rr_drain #(.N(N), .bits(B)) dut (
    .clk(clk), .rst(rst), .en(en),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_pop(fifo_pop),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready)
`ifdef FIFO_RR_DRAIN_CNT_EN
    , .xfer_count(xfer_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      fifo_empty[i] = q[i].size() == 0;
      fifo_dout[i*B +: B] = q[i].size() != 0 ? q[i][0] : '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
  endtask

  function automatic int total();
    int s = 0;
    for (int i = 0; i < N; i++) s += q[i].size();
    return s;
  endfunction

  task automatic reset_all();
    for (int i = 0; i < N; i++) q[i].delete();
    en = 1'b0;
    rst = 1'b1;
    drive();
    step();
    rst = 1'b0;
    acc.delete();
  endtask

  // reference: decide the grant from queue occupancy and check every DUT output
  always @(negedge clk) begin : cmp
    logic [N-1:0] ep;
    if (armed) begin
      m_load = 1'b0;
      m_gnt = 0;
      if (!rst && en && (!m_valid || out_ready))
        for (int k = 1; k <= N; k++) begin
          int i;
          i = (m_last + k) % N;
          if (!m_load && q[i].size() != 0) begin
            m_load = 1'b1;
            m_gnt = i;
          end
        end
      ep = m_load ? N'(1 << m_gnt) : '0;
      m_word = m_load ? q[m_gnt][0] : '0;
      chk("fifo_pop", fifo_pop, ep);
      chk("pop_of_empty", fifo_pop & fifo_empty, 0);
      chk("out_valid", out_valid, m_valid);
      chk("out_data", out_data, m_data);
      chk("out_src", out_src, m_src);
`ifdef FIFO_RR_DRAIN_CNT_EN
      chk("xfer_count", xfer_count, m_cnt);
`endif
    end
  end

  // source FIFOs react to the DUT's pops; the model advances on its own decision
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (fifo_pop[i] && q[i].size() != 0) void'(q[i].pop_front());
    if (!rst && m_valid && out_ready) acc.push_back(m_data);
`ifdef FIFO_RR_DRAIN_CNT_EN
    m_cnt <= rst ? 0 : (m_valid && out_ready && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
`endif
    if (rst) begin
      armed <= 1'b1;
      m_valid <= 1'b0;
      m_data <= '0;
      m_src <= 0;
      m_last <= N - 1;
    end else if (m_load) begin
      m_valid <= 1'b1;
      m_data <= m_word;
      m_src <= m_gnt;
      m_last <= m_gnt;
    end else if (m_valid && out_ready) m_valid <= 1'b0;
  end

  initial begin
    logic [B-1:0] rot [8];
    logic [B-1:0] hold;
    int sz;
    rot = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h11, 8'h21, 8'h31, 8'h41};
    // reset with every FIFO loaded
    rst = 1'b1; en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      q[i].push_back(B'(8'h50 + i));
      q[i].push_back(B'(8'h60 + i));
    end
    drive();
    step(); step();
    chk("rst_valid", out_valid, 0);
    chk("rst_pop", fifo_pop, 0);
    rst = 1'b0;
    #1;
    chk("first_pop", fifo_pop, 4'b0001);
    step();
    chk("first_src", out_src, 0);
    chk("first_data", out_data, 8'h50);
    repeat (10) step();
    chk("drained", total(), 0);
    // rotation over four loaded FIFOs
    reset_all();
    for (int i = 0; i < N; i++) begin
      q[i].push_back(B'(8'h10 * (i + 1)));
      q[i].push_back(B'(8'h10 * (i + 1) + 1));
    end
    drive();
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rot_data", out_data, rot[i]);
      chk("rot_valid", out_valid, 1);
    end
    step();
    chk("rot_idle", out_valid, 0);
    chk("rot_acc", acc.size(), 8);
    // single busy source
    reset_all();
    q[2].push_back(8'hA0); q[2].push_back(8'hA1); q[2].push_back(8'hA2);
    drive();
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sparse_pop", fifo_pop, 4'b0100);
      step();
      chk("sparse_data", out_data, B'(8'hA0 + i));
      chk("sparse_src", out_src, 2);
    end
    // sink stall
    reset_all();
    q[0].push_back(8'h01); q[0].push_back(8'h02); q[0].push_back(8'h03);
    q[1].push_back(8'h04); q[1].push_back(8'h05);
    drive();
    en = 1'b1; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    hold = out_data;
    chk("stall_start", hold, 8'h01);
    repeat (5) begin
      step();
      chk("stall_data", out_data, hold);
      chk("stall_pop", fifo_pop, 0);
      chk("stall_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    chk("resume_pop", fifo_pop, 4'b0010);
    step();
    chk("resume_data", out_data, 8'h04);
    chk("resume_valid", out_valid, 1);
    // enable gating: held word drains, nothing new is popped
    en = 1'b0; out_ready = 1'b0;
    step();
    chk("gate_hold", out_valid, 1);
    out_ready = 1'b1;
    step();
    chk("gate_drain", out_valid, 0);
    sz = total();
    repeat (3) begin
      step();
      chk("gate_pop", fifo_pop, 0);
    end
    chk("gate_size", total(), sz);
    // reset while a word is held
    en = 1'b1; out_ready = 1'b0;
    step();
    chk("pre_rst_valid", out_valid, 1);
    sz = total();
    rst = 1'b1;
    #1;
    chk("rst_pop_forced", fifo_pop, 0);
    step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_size", total(), sz);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();
    // randomized traffic
    reset_all();
    for (int c = 0; c < 3000; c++) begin
      en = ($urandom % 8) != 0;
      out_ready = ($urandom % 4) != 0;
      rst = ($urandom % 200) == 0;
      for (int i = 0; i < N; i++)
        if (($urandom % 3) == 0 && q[i].size() < 6) q[i].push_back(B'($urandom));
      drive();
      step();
    end
    rst = 1'b0;
`ifdef FIFO_RR_DRAIN_CNT_EN
    reset_all();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 5; j++) q[i].push_back(B'(i * 16 + j));
    drive();
    en = 1'b1; out_ready = 1'b1;
    repeat (25) step();
    chk("cnt_20", xfer_count, 20);
    chk("acc_20", acc.size(), 20);
    for (int c = 0; c < 65540; c++) begin
      if (q[0].size() < 2) q[0].push_back(B'(c));
      drive();
      step();
    end
    chk("cnt_sat", xfer_count, 16'hFFFF);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
